// File: rtl/systolic_gemm_core.sv
// rtl/systolic_gemm_core.sv - weight-stationary systolic GEMM core
// Activations skew in from the left, partial sums flow down, columns deskew on exit.
module systolic_gemm_core #(
  parameter int ROWS       = 16,
  parameter int COLS       = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wt_wr_en,
  input  logic [$clog2(ROWS)-1:0]       wt_wr_row,
  input  logic [COLS*DATA_WIDTH-1:0]    wt_wr_data,
  input  logic                          wt_commit,
  input  logic                          wt_signed,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]    in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLS*ACC_WIDTH-1:0]     out_data,
  output logic                          busy
);
  localparam int LAT = ROWS + COLS;
  localparam int CW  = $clog2(LAT + 1);
  localparam int PW  = 2 * DATA_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, SWAP} state_t;

  state_t                     state;
  logic [CW-1:0]              count;
  logic                       commit_pending, mode_pend, mode, live;
  logic [COLS*DATA_WIDTH-1:0] w_sh  [ROWS];
  logic [COLS*DATA_WIDTH-1:0] w_act [ROWS];
  logic [LAT-1:0]             vpipe;
  logic                       adv, acc, hs;
  logic [DATA_WIDTH-1:0]      lane_in [ROWS];
  logic [DATA_WIDTH-1:0]      ap [ROWS][COLS];
  logic [ACC_WIDTH-1:0]       ps [ROWS][COLS];
  logic [COLS*ACC_WIDTH-1:0]  y_flat;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = live && adv && (state != SWAP) && !commit_pending;
  assign acc      = in_valid && in_ready;
  assign hs       = out_valid && out_ready;
  assign busy     = (state != IDLE) || commit_pending;

  // One extra sign bit covers both modes with a single signed multiplier.
  function automatic logic [ACC_WIDTH-1:0] mac_term(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] w,
                                                    input logic sgn);
    logic signed [DATA_WIDTH:0] ax, wx;
    logic signed [PW-1:0]       p;
    ax = {sgn & a[DATA_WIDTH-1], a};
    wx = {sgn & w[DATA_WIDTH-1], w};
    p  = PW'(ax) * PW'(wx);
    return ACC_WIDTH'(p);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        w_sh[r]  <= '0;
        w_act[r] <= '0;
      end
    end else begin
      if (state == SWAP) w_act <= w_sh;
      if (wt_wr_en) w_sh[wt_wr_row] <= wt_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      count          <= '0;
      commit_pending <= 1'b0;
      mode_pend      <= 1'b0;
      mode           <= 1'b0;
      live           <= 1'b0;
    end else begin
      live <= 1'b1;
      if (acc && !hs) count <= count + 1'b1;
      else if (hs && !acc) count <= count - 1'b1;
      if (wt_commit) begin
        commit_pending <= 1'b1;
        mode_pend      <= wt_signed;
      end
      case (state)
        IDLE: begin
          if (commit_pending && count == '0) state <= SWAP;
          else if (acc) state <= RUN;
        end
        RUN: begin
          if (commit_pending && count == '0) state <= SWAP;
          else if (count == '0 && !acc) state <= IDLE;
        end
        SWAP: begin
          mode           <= mode_pend;
          commit_pending <= wt_commit;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [DATA_WIDTH-1:0] sk [r+1];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k <= r; k++) sk[k] <= '0;
      end else if (adv) begin
        sk[0] <= acc ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= r; k++) sk[k] <= sk[k-1];
      end
    end
    assign lane_in[r] = sk[r];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [DATA_WIDTH-1:0] a_left;
      logic [ACC_WIDTH-1:0]  ps_up;
      if (c == 0) begin : g_a0
        assign a_left = lane_in[r];
      end else begin : g_an
        assign a_left = ap[r][c-1];
      end
      if (r == 0) begin : g_p0
        assign ps_up = '0;
      end else begin : g_pn
        assign ps_up = ps[r-1][c];
      end
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ap[r][c] <= '0;
          ps[r][c] <= '0;
        end else if (adv) begin
          ap[r][c] <= a_left;
          ps[r][c] <= ps_up + mac_term(a_left, w_act[r][c*DATA_WIDTH +: DATA_WIDTH], mode);
        end
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_dsk
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_nod
      assign y_flat[c*ACC_WIDTH +: ACC_WIDTH] = ps[ROWS-1][c];
    end else begin : g_d
      logic [ACC_WIDTH-1:0] dq [D];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) dq[k] <= '0;
        end else if (adv) begin
          dq[0] <= ps[ROWS-1][c];
          for (int k = 1; k < D; k++) dq[k] <= dq[k-1];
        end
      end
      assign y_flat[c*ACC_WIDTH +: ACC_WIDTH] = dq[D-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vpipe     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      vpipe     <= {vpipe[LAT-2:0], acc};
      out_valid <= vpipe[LAT-1];
      out_data  <= y_flat;
    end
  end
endmodule

// File: tb/tb_systolic_gemm_core.sv
// tb/tb_systolic_gemm_core.sv - directed self-checking bench for systolic_gemm_core
// 4x4 grid at 32-bit and 16-bit accumulators sharing the same stimulus.
module tb_systolic_gemm_core;
  logic         clk = 1'b0;
  logic         rst_n, wt_wr_en, wt_commit, wt_signed, in_valid, out_ready;
  logic [1:0]   wt_wr_row;
  logic [31:0]  wt_wr_data, in_data;
  logic         in_ready, out_valid, busy;
  logic         in_ready16, out_valid16, busy16;
  logic [127:0] out_data;
  logic [63:0]  out_data16;

  int n_pass = 0;
  int n_total = 0;

  logic [127:0] q[$];
  logic         prev_stall = 1'b0;
  logic [127:0] held = '0;
  int           stall_bad = 0;

  logic [127:0] wa, wb;
  logic [31:0]  vecs [16];
  int           n, idx;
  logic         took, leak, seen;

  systolic_gemm_core #(.ROWS(4), .COLS(4), .DATA_WIDTH(8), .ACC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .wt_wr_en(wt_wr_en), .wt_wr_row(wt_wr_row),
    .wt_wr_data(wt_wr_data), .wt_commit(wt_commit), .wt_signed(wt_signed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

  systolic_gemm_core #(.ROWS(4), .COLS(4), .DATA_WIDTH(8), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .wt_wr_en(wt_wr_en), .wt_wr_row(wt_wr_row),
    .wt_wr_data(wt_wr_data), .wt_commit(wt_commit), .wt_signed(wt_signed),
    .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .busy(busy16));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) q.push_back(out_data);
      if (prev_stall && (!out_valid || out_data !== held)) stall_bad <= stall_bad + 1;
      prev_stall <= out_valid && !out_ready;
      held       <= out_data;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  function automatic logic [127:0] ref_vec(input logic [31:0] a, input logic [127:0] w,
                                           input logic sgn);
    logic [127:0] y;
    longint       s, ai, wi;
    logic [7:0]   av, wv;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      s = 0;
      for (int r = 0; r < 4; r++) begin
        av = a[r*8 +: 8];
        wv = w[r*32 + c*8 +: 8];
        ai = sgn ? longint'($signed(av)) : longint'(av);
        wi = sgn ? longint'($signed(wv)) : longint'(wv);
        s  = s + ai * wi;
      end
      y[c*32 +: 32] = s[31:0];
    end
    return y;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int r, input logic [31:0] d);
    wt_wr_en   = 1'b1;
    wt_wr_row  = 2'(r);
    wt_wr_data = d;
    step();
    wt_wr_en   = 1'b0;
  endtask

  task automatic load_w(input logic [127:0] w);
    for (int r = 0; r < 4; r++) write_row(r, w[r*32 +: 32]);
  endtask

  task automatic commit(input logic sgn, input string tag);
    wt_commit = 1'b1;
    wt_signed = sgn;
    step();
    wt_commit = 1'b0;
    for (int i = 0; i < 20 && busy; i++) step();
    chk(tag, busy, 0);
  endtask

  task automatic send(input logic [31:0] a);
    in_valid = 1'b1;
    in_data  = a;
    #1;
    for (int i = 0; i < 50 && !in_ready; i++) begin
      @(posedge clk);
      #2;
    end
    chk("send_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 60) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; wt_wr_en = 1'b0; wt_commit = 1'b0; wt_signed = 1'b0;
    wt_wr_row = '0; wt_wr_data = '0; in_valid = 1'b1; in_data = 32'hA5A5A5A5;
    out_ready = 1'b1;

    // Reset with in_valid held high
    repeat (2) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();
    chk("rel_in_ready", in_ready, 1);

    // Identity weights
    load_w({32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001});
    commit(1'b0, "commit_ident");
    send({8'd4, 8'd3, 8'd2, 8'd1});
    wait_out(n);
    chk("ident_latency", n, 8);
    chk("ident_data", out_data, {32'd4, 32'd3, 32'd2, 32'd1});
    step();
    chk("ident_one_cycle", out_valid, 0);

    // Signed / unsigned mode and 16-bit wrap
    load_w({4{32'hFFFFFFFF}});
    commit(1'b1, "commit_signed");
    send(32'h7F7F7F7F);
    wait_out(n);
    chk("signed_y32", out_data, {4{32'hFFFFFE04}});
    chk("signed_y16", out_data16, {4{16'hFE04}});
    step();
    commit(1'b0, "commit_unsigned");
    send(32'h7F7F7F7F);
    wait_out(n);
    chk("unsigned_y32", out_data, {4{32'd129540}});
    chk("unsigned_y16", out_data16, {4{16'hFA04}});
    step();
    send(32'hFFFFFFFF);
    wait_out(n);
    chk("unsigned_ff_y32", out_data, {4{32'd260100}});
    chk("wrap_ff_y16", out_data16, {4{16'd63492}});
    step();

    // Backpressure with random vectors and signed random weights
    for (int r = 0; r < 4; r++) wa[r*32 +: 32] = $urandom;
    for (int i = 0; i < 16; i++) vecs[i] = $urandom;
    load_w(wa);
    commit(1'b1, "commit_rand");
    q.delete();
    idx = 0;
    for (int cyc = 0; cyc < 600 && q.size() < 16; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (idx < 16);
      in_data   = vecs[(idx < 16) ? idx : 0];
      #1;
      took = in_valid && in_ready;
      step();
      if (took) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    chk("bp_count", q.size(), 16);
    chk("bp_stall_stable", stall_bad, 0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("bp_vec%0d", i), (q.size() > i) ? q[i] : '0, ref_vec(vecs[i], wa, 1'b1));

    // Commit with three vectors in flight
    q.delete();
    for (int r = 0; r < 4; r++) wb[r*32 +: 32] = $urandom;
    send(32'h01020304);
    send(32'h80FF7F10);
    send(32'hC3A55A3C);
    load_w(wb);
    wt_commit = 1'b1;
    wt_signed = 1'b0;
    step();
    wt_commit = 1'b0;
    #1;
    chk("mid_ready_blocked", in_ready, 0);
    leak = 1'b0;
    for (int i = 0; i < 60 && busy; i++) begin
      if (in_ready) leak = 1'b1;
      step();
      #1;
    end
    chk("mid_no_leak", leak, 0);
    chk("mid_swap_done", busy, 0);
    chk("mid_ready_back", in_ready, 1);
    send(32'h01020304);
    send(32'hFFFEFDFC);
    for (int i = 0; i < 60 && q.size() < 5; i++) step();
    chk("mid_count", q.size(), 5);
    chk("mid_old0", (q.size() > 0) ? q[0] : '0, ref_vec(32'h01020304, wa, 1'b1));
    chk("mid_old1", (q.size() > 1) ? q[1] : '0, ref_vec(32'h80FF7F10, wa, 1'b1));
    chk("mid_old2", (q.size() > 2) ? q[2] : '0, ref_vec(32'hC3A55A3C, wa, 1'b1));
    chk("mid_new0", (q.size() > 3) ? q[3] : '0, ref_vec(32'h01020304, wb, 1'b0));
    chk("mid_new1", (q.size() > 4) ? q[4] : '0, ref_vec(32'hFFFEFDFC, wb, 1'b0));

    // Reset with five vectors in flight
    q.delete();
    for (int i = 0; i < 5; i++) send(32'h10203040 + 32'(i));
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("rstmid_no_out", seen, 0);
    chk("rstmid_busy", busy, 0);
    send(32'h11223344);
    wait_out(n);
    chk("rstmid_valid", out_valid, 1);
    chk("rstmid_zero", out_data, 0);
    step();
    chk("rstmid_count", q.size(), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
